// File: rtl/cac_settings_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cac_settings_arbiter
// Brief    : Round-robin arbiter sharing the CAC settings RAM port among
//            NUM_REQ requesters. Runs one read or write per grant, handles the
//            RAM read latency and returns a one-hot response per requester.
//            An address at or above MEMORY_LENGTH is answered with rsp_err.
// Options  : CAC_ARB_PRIORITY_EN - requester 0 always wins when it is valid.
//            The remaining requesters rotate among themselves.
//            If undefined, all requesters rotate round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module cac_settings_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter int          ADDR_WIDTH    = 8,
  parameter int          DATA_WIDTH    = 16,
  parameter int unsigned MEMORY_LENGTH = 64,
  parameter int          RD_LATENCY    = 1
) (
  input  logic                             clk_cac,
  input  logic                             rstb_cac,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                 state;
  logic [GW-1:0]          last_grant;
  logic [GW-1:0]          cur_req;
  logic                   cur_we;
  logic                   cur_err;
  logic [CW-1:0]          wait_cnt;

  logic [GW-1:0]          winner;
  logic [GW-1:0]          cand;
  logic                   found;
  logic                   accept;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_we;
  logic                   sel_in_range;

  // Pick the first valid requester after the last grant, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    cand   = '0;
`ifdef CAC_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
`ifdef CAC_ARB_PRIORITY_EN
      if (!found && (cand != '0) && req_valid[cand]) begin
`else
      if (!found && req_valid[cand]) begin
`endif
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Select the winning request fields. The range check is a plain unsigned
  // compare of the full address against MEMORY_LENGTH.
  always_comb begin
    sel_addr     = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata    = req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
    sel_we       = req_we[winner];
    sel_in_range = (32'(sel_addr) < MEMORY_LENGTH);
    // The ready pulse is gated by reset so it stays low while reset is held.
    accept       = rstb_cac && (state == IDLE) && found;
    req_ready    = accept ? (ONE_HOT0 << winner) : '0;
  end

  // Transaction sequencer: grant, RAM strobe, read-latency wait, response.
  always_ff @(posedge clk_cac or negedge rstb_cac) begin
    if (!rstb_cac) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      cur_req    <= '0;
      cur_we     <= 1'b0;
      cur_err    <= 1'b0;
      wait_cnt   <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_req    <= winner;
            last_grant <= winner;
            cur_we     <= sel_we;
            cur_err    <= !sel_in_range;
            ram_en     <= sel_in_range;
            ram_we     <= sel_in_range & sel_we;
            ram_addr   <= sel_addr;
            ram_wdata  <= sel_wdata;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en   <= 1'b0;
          ram_we   <= 1'b0;
          wait_cnt <= '0;
          if (cur_err || cur_we) begin
            rsp_valid <= ONE_HOT0 << cur_req;
            rsp_err   <= cur_err;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == CW'(RD_LATENCY - 1)) begin
            rsp_valid <= ONE_HOT0 << cur_req;
            rsp_err   <= 1'b0;
            rsp_rdata <= ram_rdata;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cac_settings_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cac_settings_arbiter
// Brief    : Scoreboard bench for cac_settings_arbiter with a behavioural RAM.
//            A reference model predicts grants and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cac_settings_arbiter;

  localparam int N = 4, AW = 8, DW = 16, ML = 64, LAT = 1;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata = '0;

  cac_settings_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEMORY_LENGTH(ML), .RD_LATENCY(LAT)
  ) dut (
    .clk_cac(clk), .rstb_cac(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: one-cycle read latency, garbage on idle cycles.
  logic [DW-1:0] ram    [256];
  logic [DW-1:0] shadow [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end else begin
      ram_rdata <= 16'($urandom);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int req; bit err; logic [DW-1:0] rdata; int cyc; } rsp_t;
  typedef struct { int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } ram_t;

  rsp_t rsp_q[$];
  ram_t ram_q[$];
  int   grant_log[$];
  int   last_grant_m = N - 1;
  int   free_cycle = 0;
  logic [N-1:0] accepted = '0;

  // Reference arbitration: nearest valid requester after the last grant.
  function automatic int predict();
`ifdef CAC_ARB_PRIORITY_EN
    if (req_valid[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_grant_m + k) % N;
`ifdef CAC_ARB_PRIORITY_EN
      if (c != 0 && req_valid[c]) return c;
`else
      if (req_valid[c]) return c;
`endif
    end
    return -1;
  endfunction

  int            pw;
  logic [N-1:0]  exp_rdy;
  rsp_t          er;
  ram_t          em;
  logic [AW-1:0] a_m;
  bit            we_m, err_m;

  // Monitor: predicts grants, queues expected responses, checks outputs.
  always @(negedge clk) begin
    accepted = '0;
    for (int j = 0; j < N; j++)
      if (req_ready[j]) begin
        accepted[j] = 1'b1;
        grant_log.push_back(j);
      end
    if (!rstb) begin
      chk("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata,
                            ram_en, ram_we, ram_addr, ram_wdata}, '0);
      rsp_q.delete();
      ram_q.delete();
      last_grant_m = N - 1;
      free_cycle   = 0;
    end else begin
      pw      = (cyc >= free_cycle) ? predict() : -1;
      exp_rdy = (pw >= 0) ? (N'(1) << pw) : '0;
      chk("req_ready", req_ready, exp_rdy);
      if (pw >= 0) begin
        a_m   = req_addr[pw*AW +: AW];
        we_m  = req_we[pw];
        err_m = (a_m >= ML);
        er.req   = pw;
        er.err   = err_m;
        er.rdata = (err_m || we_m) ? '0 : shadow[a_m];
        er.cyc   = cyc + ((err_m || we_m) ? 2 : 2 + LAT);
        rsp_q.push_back(er);
        if (!err_m) begin
          em.cyc = cyc + 1; em.we = we_m; em.addr = a_m;
          em.wdata = req_wdata[pw*DW +: DW];
          ram_q.push_back(em);
          if (we_m) shadow[a_m] = em.wdata;
        end
        free_cycle   = cyc + ((err_m || we_m) ? 3 : 3 + LAT);
        last_grant_m = pw;
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
        er = rsp_q.pop_front();
        chk("rsp", {rsp_valid, rsp_err, rsp_rdata, 32'(cyc)},
                   {N'(1) << er.req, er.err, er.rdata, 32'(er.cyc)});
      end else begin
        chk("rsp_unexpected", rsp_valid, '0);
      end
      if (ram_q.size() > 0 && ram_q[0].cyc <= cyc) begin
        em = ram_q.pop_front();
        chk("ram_access", {ram_en, ram_we, ram_addr, ram_we ? ram_wdata : 16'h0, 32'(cyc)},
                          {1'b1, em.we, em.addr, em.we ? em.wdata : 16'h0, 32'(em.cyc)});
      end else begin
        chk("ram_unexpected", ram_en, 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    req_valid = req_valid & ~accepted;
  endtask

  task automatic set_req(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  // Raise a request and wait, bounded, until it is accepted.
  task automatic issue(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    set_req(i, we, a, d);
    for (int t = 0; t < 30 && !got; t++) begin
      @(posedge clk); #1;
      if (accepted[i]) got = 1'b1;
      req_valid = req_valid & ~accepted;
    end
    chk("accept_timeout", got, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    req_valid = '0;
    while ((rsp_q.size() != 0 || cyc < free_cycle) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", rsp_q.size(), 0);
  endtask

  task automatic rand_stim();
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i]) begin
        if ($urandom_range(0, 2) == 0)
          set_req(i, $urandom_range(0, 9) < 4,
                  ($urandom_range(0, 9) == 0) ? 8'($urandom_range(64, 255))
                                              : 8'($urandom_range(0, 63)),
                  16'($urandom));
      end else if ($urandom_range(0, 29) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  int base;
  int n3;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'($urandom);
      shadow[i] = ram[i];
    end
    ram[5] = 16'hA5A5;
    shadow[5] = 16'hA5A5;

    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;

    // Directed: single read, write-then-read at the top address, out of range.
    issue(2, 1'b0, 8'd5, 16'h0);
    drain();
    issue(0, 1'b1, 8'd63, 16'h1234);
    issue(0, 1'b0, 8'd63, 16'h0);
    drain();
    issue(1, 1'b0, 8'd64, 16'h0);
    drain();

    // Withdrawal: requester 3 drops valid while a read is in progress.
    base = grant_log.size();
    issue(0, 1'b0, 8'd10, 16'h0);
    set_req(3, 1'b0, 8'd20, 16'h0);
    step();
    req_valid[3] = 1'b0;
    repeat (6) step();
    n3 = 0;
    for (int k = base; k < grant_log.size(); k++) if (grant_log[k] == 3) n3++;
    chk("withdrawn_grants", n3, 0);
    drain();

    // Randomized traffic.
    repeat (600) begin
      step();
      rand_stim();
    end
    drain();

    // Fairness: every requester valid continuously from reset.
    rstb = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'($urandom_range(0, 63)), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    base = grant_log.size();
    rstb = 1'b1;
    repeat (40) begin
      step();
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) set_req(i, 1'b0, 8'($urandom_range(0, 63)), 16'h0);
    end
    for (int k = 0; k < 8; k++) begin
`ifdef CAC_ARB_PRIORITY_EN
      chk("fair_order", (grant_log.size() > base + k) ? grant_log[base + k] : -1, 0);
`else
      chk("fair_order", (grant_log.size() > base + k) ? grant_log[base + k] : -1, k % N);
`endif
    end
    drain();

    // Reset in the WAIT state of a read.
    issue(2, 1'b0, 8'd5, 16'h0);
    set_req(1, 1'b0, 8'd7, 16'h0);
    set_req(0, 1'b0, 8'd8, 16'h0);
    set_req(3, 1'b1, 8'd9, 16'hBEEF);
    @(posedge clk); #1;
    rstb = 1'b0;
    #1;
    chk("reset_mid_read", {req_ready, rsp_valid, rsp_err, rsp_rdata,
                           ram_en, ram_we, ram_addr, ram_wdata}, '0);
    repeat (2) @(posedge clk);
    #1;
    base = grant_log.size();
    rstb = 1'b1;
    for (int t = 0; t < 10 && grant_log.size() == base; t++) step();
    chk("first_grant_after_reset", (grant_log.size() > base) ? grant_log[base] : -1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cac_settings_arbiter.md
# cac_settings_arbiter

Round-robin arbiter that shares the communication-and-control settings RAM port among several requesters (UART command channel, housekeeping, future channels). Accepts one read or write per grant over a valid/ready handshake, sequences the RAM access including fixed read latency, and returns a per-requester response with an address-range error flag. Sits inside the CAC subsystem on the 10 MHz CAC clock domain, between requesters and the settings RAM.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 8, settings address width
- DATA_WIDTH, 16, settings word width
- MEMORY_LENGTH, 64, valid words; addresses >= this are errors
- RD_LATENCY, 1, RAM read latency in cycles (1..4)
- clk_cac  in  1  CAC clock
- rstb_cac  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  request pending per requester
- req_ready  out  NUM_REQ  one-hot accept pulse
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid  out  NUM_REQ  one-hot one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  read data, shared, valid with rsp_valid
- rsp_err  out  1  address out of range, valid with rsp_valid
- ram_en, ram_we  out  1 each  RAM strobe and write enable
- ram_addr  out  ADDR_WIDTH ; ram_wdata  out  DATA_WIDTH
- ram_rdata  in  DATA_WIDTH  RAM read data, RD_LATENCY after ram_en

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req_valid, winner = first valid requester searching from last_grant+1 modulo NUM_REQ; req_ready[winner]=1 combinationally that cycle; addr/we/wdata/winner captured; last_grant<=winner; -> ACCESS.
- ACCESS: if addr < MEMORY_LENGTH: ram_en=1, ram_we=we, ram_addr/ram_wdata = captured values; writes -> RESP, reads -> WAIT. If addr out of range: no ram_en; -> RESP with err.
- WAIT: count RD_LATENCY cycles; on last, capture ram_rdata; -> RESP.
- RESP: rsp_valid[winner]=1, rsp_err, rsp_rdata (0 for writes and errors); -> IDLE.
- req_ready only asserted in IDLE; a requester must hold valid/addr/we/wdata stable until ready.
- Dropping req_valid before ready is allowed; request silently withdrawn.
- Requests are never merged; one outstanding transaction at a time.
- Width rule: range check is unsigned, full ADDR_WIDTH compare.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first).
- Handshake in cycle T: ram_en at T+1; write/error rsp_valid at T+2; read rdata sampled at T+1+RD_LATENCY, rsp_valid at T+2+RD_LATENCY.
- Next accept earliest one cycle after RESP (IDLE); read throughput one per 3+RD_LATENCY cycles, write one per 3.
- Simultaneous requests: strict rotation; a continuously requesting client is served at most once per NUM_REQ grants when all are active.
- Reset mid-transaction: immediate return to reset values; no response issued; RAM write in progress may or may not have completed; requesters reissue.
- All RAM-side outputs are registered (glitch-free).

## Configuration
- CAC_ARB_PRIORITY_EN defined: requester 0 (UART command channel) has strict priority; when req_valid[0] is high in IDLE it always wins; requesters 1..NUM_REQ-1 rotate among themselves when requester 0 is idle.
- Not defined: pure round-robin over all NUM_REQ requesters.

## Test plan
- Single read: req 2 reads addr 5 with RAM[5]=16'hA5A5, RD_LATENCY=1 -> req_ready[2] at T, ram_en at T+1, rsp_valid=4'b0100 at T+3, rsp_rdata=16'hA5A5, rsp_err=0.
- Write then read: req 0 writes 16'h1234 to addr 63, then reads addr 63 -> write rsp at T+2 with rdata 0, read returns 16'h1234.
- Out-of-range: req 1 reads addr 64 -> no ram_en, rsp_valid[1] at T+2, rsp_err=1, rsp_rdata=0.
- Fairness: all four requesters valid continuously from reset -> grant order 0,1,2,3,0,...; with CAC_ARB_PRIORITY_EN -> 0 every grant while held, else 1,2,3 rotating.
- Withdrawal: req 3 drops valid while another transaction is in progress -> req 3 never granted, no rsp_valid[3].
- Reset mid-read: assert rstb_cac=0 in WAIT -> all outputs zero immediately, no rsp_valid after release, first grant goes to requester 0.
